// File: rtl/pipo_arb_pkg.sv
// Shared types and constants for the round-robin PIPO load arbiter.
package pipo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int CNT_W    = 4;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;

  // Out-of-range hold lengths are pinned to the nearest legal value.
  function automatic int clamp_hold(input int hold);
    if (hold < HOLD_MIN) return HOLD_MIN;
    if (hold > HOLD_MAX) return HOLD_MAX;
    return hold;
  endfunction

endpackage

// File: rtl/pipo_reg.sv
// WIDTH-bit parallel-in/parallel-out storage register with load enable.
module pipo_reg #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (LOAD) q_d = D;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/pipo_load_arbiter.sv
// Two-requester round-robin arbiter that loads a shared PIPO register and
// then locks it for HOLD_CYCLES cycles so each loaded value stays visible.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0_IN,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1_IN,
  output logic             GNT0,
  output logic             GNT1,
  output logic [WIDTH-1:0] Q,
  output logic             OWNER,
  output logic             BUSY
);

  localparam int             HOLD_EFF = clamp_hold(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_EFF - 1);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;

  logic             load;
  logic             win;
  logic [WIDTH-1:0] load_data;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          gnt0_d  = ~win;
          gnt1_d  = win;
          owner_d = win;
          ptr_d   = ~win;
          cnt_d   = CNT_INIT;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == HOLD);
  end

  // Output / datapath control: requests only matter in IDLE, tie goes to ptr
  always_comb begin
    load      = (state_q == IDLE) && (REQ0 || REQ1);
    win       = (REQ0 && REQ1) ? ptr_q : REQ1;
    load_data = win ? D1_IN : D0_IN;
  end

  pipo_reg #(.WIDTH(WIDTH)) u_reg (
    .CLK   (CLK),
    .RST_N (RST_N),
    .LOAD  (load),
    .D     (load_data),
    .Q     (Q)
  );

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter: expected grants are queued as
// requests are raised and retired when the DUT pulses GNT0/GNT1.
module tb_pipo_load_arbiter;

  localparam int WIDTH = 3;
  localparam int HOLD  = 2;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
  } gnt_exp_t;

  logic             CLK, RST_N;
  logic             REQ0, REQ1;
  logic [WIDTH-1:0] D0_IN, D1_IN;
  logic             GNT0, GNT1, OWNER, BUSY;
  logic [WIDTH-1:0] Q;

  gnt_exp_t exp_q[$];
  int       n_chk, n_fail;
  int       cyc, last_gnt_cyc, gnt_cyc;
  logic     gnt_seen;
  logic     mptr;

  pipo_load_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ0  (REQ0),
    .D0_IN (D0_IN),
    .REQ1  (REQ1),
    .D1_IN (D1_IN),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .Q     (Q),
    .OWNER (OWNER),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [WIDTH-1:0] data);
    gnt_exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one edge, sample 1ns later and retire any grant seen.
  task automatic tick();
    gnt_exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    gnt_seen = GNT0 || GNT1;
    if (GNT0 && GNT1) chk("gnt_exclusive", 1, 0);
    if (gnt_seen) begin
      gnt_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("gnt_unexpected", {GNT1, GNT0}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("gnt_id", GNT1, e.id);
        chk("gnt_q", Q, e.data);
        chk("gnt_owner", OWNER, e.id);
        chk("gnt_busy", BUSY, 1);
      end
      if (last_gnt_cyc >= 0) chk("gnt_spacing_ok", (cyc - last_gnt_cyc) >= HOLD + 1, 1);
      last_gnt_cyc = cyc;
      // Requester drops REQ and moves on; its new data must not leak into Q.
      if (GNT0) begin REQ0 = 1'b0; D0_IN = WIDTH'($urandom); end
      if (GNT1) begin REQ1 = 1'b0; D1_IN = WIDTH'($urandom); end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < 40) begin
      tick();
      n++;
    end
    chk(tag, (exp_q.size() == 0) && !BUSY, 1);
  endtask

  task automatic pulse_reset_check(input string tag);
    #2 RST_N = 1'b0;
    #1;
    chk({tag, "_q"}, Q, 0);
    chk({tag, "_gnt"}, {GNT1, GNT0}, 0);
    chk({tag, "_owner"}, OWNER, 0);
    chk({tag, "_busy"}, BUSY, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    last_gnt_cyc = -1;
    mptr = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] q_hold;
    int g0;
    n_chk = 0; n_fail = 0; cyc = 0; last_gnt_cyc = -1; gnt_cyc = 0;
    gnt_seen = 1'b0; mptr = 1'b0;
    RST_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; D0_IN = '0; D1_IN = '0;

    #12;
    chk("rst_q", Q, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_gnt", {GNT1, GNT0}, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single request from requester 0
    REQ0 = 1'b1; D0_IN = 3'b100; push(0, 3'b100);
    tick();
    chk("single_gnt_first_edge", gnt_seen, 1);
    tick();
    chk("single_gnt_pulse", GNT0, 0);
    chk("single_busy_e1", BUSY, 1);
    chk("single_q_e1", Q, 3'b100);
    tick();
    chk("single_busy_e2", BUSY, 0);
    chk("single_q_e2", Q, 3'b100);

    // Asynchronous reset between edges clears a loaded Q
    pulse_reset_check("rst_async");

    // Simultaneous requests: ptr=0 so requester 0 wins, then 1
    REQ0 = 1'b1; REQ1 = 1'b1; D0_IN = 3'b110; D1_IN = 3'b011;
    push(0, 3'b110); push(1, 3'b011);
    tick();
    chk("sim_first_gnt", gnt_seen, 1);
    g0 = gnt_cyc;
    tick(); chk("sim_hold_q1", Q, 3'b110); chk("sim_no_gnt1", GNT1, 0);
    tick(); chk("sim_hold_q2", Q, 3'b110); chk("sim_no_gnt2", GNT1, 0);
    tick();
    chk("sim_second_gnt", gnt_seen, 1);
    chk("sim_spacing", gnt_cyc - g0, HOLD + 1);
    drain("sim_drain1");
    // Both again: pointer now favours requester 0
    REQ0 = 1'b1; REQ1 = 1'b1; D0_IN = 3'b001; D1_IN = 3'b111;
    push(0, 3'b001); push(1, 3'b111);
    drain("sim_drain2");

    // Request arriving during HOLD is served after the lock expires
    REQ0 = 1'b1; D0_IN = 3'b010; push(0, 3'b010);
    tick();
    g0 = gnt_cyc;
    REQ1 = 1'b1; D1_IN = 3'b011; push(1, 3'b011);
    tick(); chk("hold_q_e1", Q, 3'b010); chk("hold_gnt_e1", GNT1, 0);
    tick(); chk("hold_q_e2", Q, 3'b010); chk("hold_gnt_e2", GNT1, 0);
    tick();
    chk("hold_gnt_e3", GNT1, 1);
    chk("hold_spacing", gnt_cyc - g0, HOLD + 1);
    drain("hold_drain");

    // Reset mid-HOLD with requester 1 pending
    REQ0 = 1'b1; D0_IN = 3'b101; push(0, 3'b101);
    tick();
    REQ1 = 1'b1; D1_IN = 3'b011;
    tick();
    chk("midhold_busy", BUSY, 1);
    q_hold = Q;
    chk("midhold_q_pre", q_hold, 3'b101);
    pulse_reset_check("rst_midhold");
    push(1, 3'b011);
    tick();
    chk("midhold_regrant", gnt_seen, 1);
    mptr = 1'b0;
    drain("midhold_drain");

    // Random single/dual request rounds against a tiny pointer model
    for (int i = 0; i < 10; i++) begin
      int pat;
      logic [WIDTH-1:0] a, b;
      pat = $urandom_range(1, 3);
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      D0_IN = a; D1_IN = b;
      if (pat == 3) begin
        REQ0 = 1'b1; REQ1 = 1'b1;
        if (mptr) begin push(1, b); push(0, a); end
        else      begin push(0, a); push(1, b); end
      end else if (pat == 1) begin
        REQ0 = 1'b1; push(0, a); mptr = 1'b1;
      end else begin
        REQ1 = 1'b1; push(1, b); mptr = 1'b0;
      end
      drain("rand_drain");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
